// File: rtl/floor_request_scheduler_if.sv
// floor_request_scheduler_if: call-button, car-status and target-floor bundle between the scheduler and its environment.
interface floor_request_scheduler_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 4
);
    logic [NUM_FLOORS-1:0] btn_in;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  car_idle;
    logic [FLOOR_W-1:0]    requested_floor;
    logic                  req_valid;
    logic [NUM_FLOORS-1:0] pending;
    logic                  door_open;
    modport master (
        output btn_in, current_floor, car_idle,
        input  requested_floor, req_valid, pending, door_open
    );
    modport slave (
        input  btn_in, current_floor, car_idle,
        output requested_floor, req_valid, pending, door_open
    );
endinterface

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: debounces call buttons, latches requests and issues SCAN-ordered targets with a door dwell.
module floor_request_scheduler #(
    parameter int NUM_FLOORS      = 8,
    parameter int FLOOR_W         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DOOR_DWELL      = 16
) (
    input logic                     clk,
    input logic                     reset,
    floor_request_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DW = $clog2(DOOR_DWELL + 1);
    typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;
    state_t                state;
    logic [NUM_FLOORS-1:0] sync1, sync2, press, sets, clrs, cur_hot, pend;
    logic [CW-1:0]         cnt [NUM_FLOORS];
    logic [DW-1:0]         dcnt;
    logic                  dir_up, cur_ok, hit, pick, arrive, have_above, have_below;
    logic [FLOOR_W-1:0]    cur, above, below, target;
    assign bus.pending = pend;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
            for (int i = 0; i < NUM_FLOORS; i++)
                cnt[i] <= !sync2[i] ? '0 : cnt[i] == CW'(DEBOUNCE_CYCLES) ? cnt[i] : cnt[i] + 1'b1;
        end
    end
    // A press qualifies only on the edge where the counter reaches its limit, so holding never re-fires.
    always_comb begin
        press = '0;
        for (int i = 0; i < NUM_FLOORS; i++) press[i] = sync2[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
    end
    always_comb begin
        cur_ok  = int'(bus.current_floor) < NUM_FLOORS;
        cur     = cur_ok ? bus.current_floor : '0;
        cur_hot = cur_ok ? NUM_FLOORS'(1) << bus.current_floor : '0;
        hit     = state == IDLE && bus.car_idle && |(pend & cur_hot);
        pick    = state == IDLE && bus.car_idle && cur_ok && |pend && !hit;
        arrive  = state == SEEK && bus.car_idle && bus.current_floor == bus.requested_floor;
        sets    = press & ~(state == DWELL ? cur_hot : '0);
        clrs    = hit ? cur_hot : arrive ? NUM_FLOORS'(1) << bus.requested_floor : '0;
        have_above = 1'b0;
        above      = '0;
        have_below = 1'b0;
        below      = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pend[i] && i > int'(bus.current_floor)) begin
                have_above = 1'b1;
                above      = FLOOR_W'(i);
            end
        for (int i = 0; i < NUM_FLOORS; i++)
            if (pend[i] && i < int'(bus.current_floor)) begin
                have_below = 1'b1;
                below      = FLOOR_W'(i);
            end
        target = dir_up ? (have_above ? above : below) : (have_below ? below : above);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            pend                <= '0;
            dir_up              <= 1'b1;
            dcnt                <= '0;
            bus.requested_floor <= '0;
            bus.req_valid       <= 1'b0;
            bus.door_open       <= 1'b0;
        end else begin
            pend <= (pend | sets) & ~clrs;
            case (state)
                IDLE: begin
                    bus.requested_floor <= pick ? target : cur;
                    if (hit) begin
                        state         <= DWELL;
                        bus.door_open <= 1'b1;
                        dcnt          <= DW'(DOOR_DWELL - 1);
                    end else if (pick) begin
                        state         <= SEEK;
                        bus.req_valid <= 1'b1;
                        dir_up        <= dir_up ? have_above : !have_below;
                    end
                end
                SEEK: if (arrive) begin
                    state         <= DWELL;
                    bus.req_valid <= 1'b0;
                    bus.door_open <= 1'b1;
                    dcnt          <= DW'(DOOR_DWELL - 1);
                end
                DWELL: begin
                    bus.requested_floor <= cur;
                    if (dcnt == '0) begin
                        state         <= IDLE;
                        bus.door_open <= 1'b0;
                    end else dcnt <= dcnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: directed scenarios plus random traffic checked against a run-length/SCAN reference model.
module tb_floor_request_scheduler;
    localparam int N = 8, FW = 4, DB = 4, DWL = 16;
    logic clk = 0, reset = 1;
    int   vecs = 0, fails = 0;
    floor_request_scheduler_if #(.NUM_FLOORS(N), .FLOOR_W(FW)) bus();
    floor_request_scheduler #(.NUM_FLOORS(N), .FLOOR_W(FW), .DEBOUNCE_CYCLES(DB), .DOOR_DWELL(DWL))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    // Reference model: a press is a high run of exactly DB samples seen two edges late.
    logic [N-1:0]  m_pend = '0, m_press, m_clr;
    logic [FW-1:0] m_req = '0;
    logic          m_valid = 0, m_dir = 1;
    int            m_mode = 0, m_left = 0, m_cf, m_up, m_dn;
    bit            m_ok;
    int            rl [N], rl_prev [N];
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_pend = '0; m_req = '0; m_valid = 0; m_dir = 1; m_mode = 0; m_left = 0;
            for (int i = 0; i < N; i++) begin rl[i] = 0; rl_prev[i] = 0; end
        end else begin
            m_cf = int'(bus.current_floor);
            m_ok = m_cf < N;
            m_clr = '0;
            for (int i = 0; i < N; i++) begin
                m_press[i] = rl_prev[i] == DB;
                rl_prev[i] = rl[i];
                rl[i] = bus.btn_in[i] ? rl[i] + 1 : 0;
            end
            if (m_mode == 2 && m_ok) m_press[m_cf] = 1'b0;
            if (m_mode == 0) begin
                if (!m_ok) m_req = '0;
                else if (bus.car_idle && m_pend[m_cf]) begin
                    m_clr[m_cf] = 1'b1; m_mode = 2; m_left = DWL; m_req = FW'(m_cf);
                end else if (bus.car_idle && m_pend != 0) begin
                    m_up = -1; m_dn = -1;
                    for (int f = N - 1; f > m_cf; f--) if (m_pend[f]) m_up = f;
                    for (int f = 0; f < m_cf; f++) if (m_pend[f]) m_dn = f;
                    if (m_dir) begin
                        if (m_up >= 0) m_req = FW'(m_up); else begin m_req = FW'(m_dn); m_dir = 0; end
                    end else begin
                        if (m_dn >= 0) m_req = FW'(m_dn); else begin m_req = FW'(m_up); m_dir = 1; end
                    end
                    m_valid = 1; m_mode = 1;
                end else m_req = FW'(m_cf);
            end else if (m_mode == 1) begin
                if (bus.car_idle && m_cf == int'(m_req)) begin
                    m_clr[m_req] = 1'b1; m_valid = 0; m_mode = 2; m_left = DWL;
                end
            end else begin
                m_req = m_ok ? FW'(m_cf) : '0;
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
            m_pend = (m_pend | m_press) & ~m_clr;
        end
    end
    function automatic logic [FW+N+1:0] dut_vec();
        return {bus.requested_floor, bus.req_valid, bus.pending, bus.door_open};
    endfunction
    function automatic logic [FW+N+1:0] exp_vec();
        return {m_req, m_valid, m_pend, m_mode == 2};
    endfunction
    task automatic serve(output int got);
        int t = 0, cf;
        got = -1;
        while (!bus.req_valid && t < 60) begin @(negedge clk); t++; end
        if (!bus.req_valid) return;
        got = int'(bus.requested_floor);
        bus.car_idle = 0;
        cf = int'(bus.current_floor);
        while (cf != got) begin
            repeat (2) @(negedge clk);
            cf = cf < got ? cf + 1 : cf - 1;
            bus.current_floor = FW'(cf);
        end
        bus.car_idle = 1;
        t = 0;
        while (!bus.door_open && t < 10) begin @(negedge clk); t++; end
        t = 0;
        while (bus.door_open && t < 40) begin @(negedge clk); t++; end
    endtask
    task automatic test_reset();
        bus.btn_in = '0; bus.current_floor = '0; bus.car_idle = 1;
        #2 reset = 0;
        #1 vecs++;
        if (dut_vec() !== '0) begin fails++; $display("FAIL reset_async got=%h exp=0", dut_vec()); end
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk); vecs++;
        if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask
    task automatic test_press_serve();
        int cnt = 0;
        bus.btn_in = 8'h04;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); vecs++;
            if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL press_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            if (c == 4) begin vecs++; if (bus.pending !== 8'h00) begin fails++; $display("FAIL press_early got=%h exp=00", bus.pending); end end
            if (c == 5) begin vecs++; if (bus.pending !== 8'h04) begin fails++; $display("FAIL press_latency got=%h exp=04", bus.pending); end end
            if (c == 6) begin vecs++; if ({bus.req_valid, bus.requested_floor} !== {1'b1, 4'd2}) begin fails++; $display("FAIL press_target got=%b/%0d exp=1/2", bus.req_valid, bus.requested_floor); end end
        end
        bus.btn_in = '0; bus.car_idle = 0; bus.current_floor = 4'd1;
        repeat (3) @(negedge clk);
        bus.current_floor = 4'd2;
        repeat (2) @(negedge clk);
        bus.car_idle = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); vecs++;
            if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL serve_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            if (bus.door_open) cnt++;
        end
        vecs++;
        if (cnt != DWL) begin fails++; $display("FAIL door_dwell got=%0d exp=%0d", cnt, DWL); end
        vecs++;
        if ({bus.pending, bus.req_valid, bus.requested_floor} !== {8'h00, 1'b0, 4'd2}) begin
            fails++; $display("FAIL serve_end got=%h/%b/%0d exp=00/0/2", bus.pending, bus.req_valid, bus.requested_floor);
        end
    endtask
    task automatic test_glitch();
        bus.btn_in = 8'h20;
        repeat (2) @(negedge clk);
        bus.btn_in = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); vecs++;
            if ({bus.pending, bus.requested_floor} !== {8'h00, 4'd2} || dut_vec() !== exp_vec()) begin
                fails++; $display("FAIL glitch c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
    endtask
    task automatic test_scan_order();
        int got [3];
        int exp [3] = '{5, 6, 1};
        bus.car_idle = 0; bus.current_floor = 4'd3; bus.btn_in = 8'h62;
        repeat (7) @(negedge clk);
        bus.btn_in = '0;
        repeat (3) @(negedge clk);
        vecs++;
        if (bus.pending !== 8'h62 || dut_vec() !== exp_vec()) begin fails++; $display("FAIL scan_latch got=%h exp=62", bus.pending); end
        bus.car_idle = 1;
        for (int k = 0; k < 3; k++) serve(got[k]);
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if (got[k] != exp[k]) begin fails++; $display("FAIL scan_order k=%0d got=%0d exp=%0d", k, got[k], exp[k]); end
        end
        vecs++;
        if (dut_vec() !== exp_vec() || bus.pending !== 8'h00) begin fails++; $display("FAIL scan_end got=%h exp=%h", dut_vec(), exp_vec()); end
    endtask
    task automatic test_inplace();
        bit seen_valid = 0, seen_door = 0, bad_floor = 0;
        bus.car_idle = 0; bus.current_floor = 4'd4;
        repeat (2) @(negedge clk);
        bus.car_idle = 1;
        repeat (2) @(negedge clk);
        bus.btn_in = 8'h10;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); vecs++;
            if (c == 12) bus.btn_in = '0;
            if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL inplace_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            seen_valid |= bus.req_valid;
            seen_door  |= bus.door_open;
            bad_floor  |= bus.requested_floor !== 4'd4;
        end
        vecs++;
        if ({seen_valid, seen_door, bad_floor} !== 3'b010) begin
            fails++; $display("FAIL inplace valid/door/badfloor got=%b%b%b exp=010", seen_valid, seen_door, bad_floor);
        end
    endtask
    task automatic test_back_to_back();
        int t = 0, rises = 0;
        bit prev;
        bus.btn_in = 8'h40;
        repeat (6) @(negedge clk);
        bus.btn_in = '0;
        while (!bus.req_valid && t < 20) begin @(negedge clk); t++; end
        vecs++;
        if ({bus.req_valid, bus.requested_floor} !== {1'b1, 4'd6}) begin fails++; $display("FAIL b2b_first got=%b/%0d exp=1/6", bus.req_valid, bus.requested_floor); end
        bus.car_idle = 0; bus.current_floor = 4'd5; bus.btn_in = 8'h04;
        prev = bus.pending[2];
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); vecs++;
            if (bus.requested_floor !== 4'd6 || dut_vec() !== exp_vec()) begin fails++; $display("FAIL b2b_hold c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
            if (bus.pending[2] && !prev) rises++;
            prev = bus.pending[2];
        end
        bus.btn_in = '0; bus.current_floor = 4'd6; bus.car_idle = 1;
        t = 0;
        while (!bus.door_open && t < 10) begin @(negedge clk); t++; end
        t = 0;
        while (bus.door_open && t < 40) begin @(negedge clk); t++; end
        t = 0;
        while (!bus.req_valid && t < 10) begin @(negedge clk); t++; end
        vecs++;
        if ({bus.req_valid, bus.requested_floor, bus.pending} !== {1'b1, 4'd2, 8'h04} || rises != 1) begin
            fails++; $display("FAIL b2b_next got=%b/%0d/%h rises=%0d exp=1/2/04 rises=1", bus.req_valid, bus.requested_floor, bus.pending, rises);
        end
    endtask
    task automatic test_reset_mid();
        int t = 0;
        bus.car_idle = 0; bus.current_floor = 4'd5;
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1 vecs++;
        if (dut_vec() !== '0) begin fails++; $display("FAIL reset_mid got=%h exp=0", dut_vec()); end
        repeat (2) @(negedge clk);
        reset = 1;
        bus.current_floor = 4'd3; bus.btn_in = 8'h22;
        repeat (7) @(negedge clk);
        bus.btn_in = '0;
        repeat (2) @(negedge clk);
        bus.car_idle = 1;
        while (!bus.req_valid && t < 10) begin @(negedge clk); t++; end
        vecs++;
        if ({bus.req_valid, bus.requested_floor} !== {1'b1, 4'd5}) begin fails++; $display("FAIL reset_dir got=%b/%0d exp=1/5", bus.req_valid, bus.requested_floor); end
    endtask
    task automatic test_random();
        int hold [N];
        int cf;
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] > 0) hold[i]--;
                else if ($urandom_range(0, 24) == 0) hold[i] = $urandom_range(1, 9);
                bus.btn_in[i] = hold[i] > 0;
            end
            cf = int'(bus.current_floor);
            if (m_valid && cf != int'(m_req)) begin
                bus.car_idle = 0;
                if ($urandom_range(0, 2) == 0) bus.current_floor = FW'(cf < int'(m_req) ? cf + 1 : cf - 1);
            end else if (!m_valid && $urandom_range(0, 39) == 0) bus.current_floor = FW'($urandom_range(0, 15));
            else bus.car_idle = $urandom_range(0, 3) != 0;
            @(negedge clk); vecs++;
            if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); end
        end
    endtask
    initial begin
        test_reset();
        test_press_serve();
        test_glitch();
        test_scan_order();
        test_inplace();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
